// File: rtl/rr_arb_fifo_if.sv
// rr_arb_fifo_if: requester/consumer handshake bundle for rr_arb_fifo.
// master drives req/req_data/pop/err_clr; slave (the arbiter FIFO) drives the rest.
interface rr_arb_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        grant;
    logic                    pop;
    logic [DATA_W-1:0]       rd_data;
    logic                    full;
    logic                    empty;
    logic [CW-1:0]           count;
    logic                    err_clr;
    logic                    error_flag;

    modport master (
        output req, req_data, pop, err_clr,
        input  grant, rd_data, full, empty, count, error_flag
    );

    modport slave (
        input  req, req_data, pop, err_clr,
        output grant, rd_data, full, empty, count, error_flag
    );
endinterface

// File: rtl/rr_arb_fifo.sv
// rr_arb_fifo: 4-way round-robin arbiter writing into a show-ahead FIFO.
// Ports: clk, rst_n (async active-low), bus (rr_arb_fifo_if.slave).
module rr_arb_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_arb_fifo_if.slave      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [1:0]        prio;
    logic              err;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [N_REQ-1:0]  gnt;
    logic [1:0]        gidx;
    logic [1:0]        idx;
    logic              found;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop_ok;
    logic              under;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // Scan requesters starting at prio; first hit wins.
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = prio + 2'(i);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found && !full)
            gnt[gidx] = 1'b1;
    end

    assign push   = found && !full;
    assign pop_ok = bus.pop && !empty;
    assign under  = bus.pop && empty;

    always_comb begin
        if (push)
            assert (!full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            prio   <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                prio   <= gidx + 2'd1;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop_ok)
                cnt <= cnt + CW'(1);
            else if (pop_ok && !push)
                cnt <= cnt - CW'(1);
            // Underflow has priority over a same-cycle clear.
            if (under)
                err <= 1'b1;
            else if (bus.err_clr)
                err <= 1'b0;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.req_data[int'(gidx)*DATA_W +: DATA_W];
    end

    assign bus.grant      = gnt;
    assign bus.rd_data    = mem[rd_ptr];
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = cnt;
    assign bus.error_flag = err;
endmodule

// File: tb/tb_rr_arb_fifo.sv
// tb_rr_arb_fifo: directed self-checking bench for rr_arb_fifo.
// Drives inputs 1ns after the rising edge and samples before the next one.
module tb_rr_arb_fifo;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int N_REQ  = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    rr_arb_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .N_REQ(N_REQ)) bus();

    rr_arb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .N_REQ(N_REQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [31:0] d);
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic rr_words;
        for (int i = 0; i < 4; i++)
            set_word(i, 32'h1000_0000 | 32'(i));
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req = 4'b0000;
        bus.pop = 1'b0;
        bus.err_clr = 1'b0;
        rr_words();
        #12;
        checks++;
        if (bus.count !== 5'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", bus.count);
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_empty: got %b want 1", bus.empty);
        end
        checks++;
        if (bus.full !== 1'b0) begin
            errors++;
            $display("FAIL reset_full: got %b want 0", bus.full);
        end
        checks++;
        if (bus.error_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b want 0", bus.error_flag);
        end
        bus.req = 4'b0110;
        #1;
        checks++;
        if (bus.grant !== 4'b0010) begin
            errors++;
            $display("FAIL reset_grant: got %b want 0010", bus.grant);
        end
        bus.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid;
        bus.req = 4'b0001;
        repeat (5) tick();
        bus.req = 4'b0000;
        checks++;
        if (bus.count !== 5'd5) begin
            errors++;
            $display("FAIL mid_count5: got %0d want 5", bus.count);
        end
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0000;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.count !== 5'd0) begin
            errors++;
            $display("FAIL mid_rst_count: got %0d want 0", bus.count);
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_flags: got e=%b f=%b want e=1 f=0",
                     bus.empty, bus.full);
        end
        checks++;
        if (bus.error_flag !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_err: got %b want 0", bus.error_flag);
        end
        bus.req = 4'b0100;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.grant !== 4'b0100) begin
            errors++;
            $display("FAIL mid_first_grant: got %b want 0100", bus.grant);
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.count !== 5'd0) begin
            errors++;
            $display("FAIL mid_post_count: got %0d want 0", bus.count);
        end
    endtask

    task automatic test_rr_fill;
        logic [3:0] exp_g;
        rr_words();
        bus.req = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            #1;
            exp_g = 4'b0001 << (k % 4);
            checks++;
            if (bus.grant !== exp_g) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b want %b",
                         k, bus.grant, exp_g);
            end
            tick();
        end
        #1;
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
            errors++;
            $display("FAIL rr_full: got f=%b c=%0d want f=1 c=16",
                     bus.full, bus.count);
        end
        checks++;
        if (bus.grant !== 4'b0000) begin
            errors++;
            $display("FAIL rr_full_grant: got %b want 0000", bus.grant);
        end
        bus.req = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (bus.rd_data !== (32'h1000_0000 | 32'(k % 4))) begin
                errors++;
                $display("FAIL rr_drain[%0d]: got %h want %h", k,
                         bus.rd_data, 32'h1000_0000 | 32'(k % 4));
            end
            bus.pop = 1'b1;
            tick();
        end
        bus.pop = 1'b0;
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL rr_empty: got %b want 1", bus.empty);
        end
    endtask

    task automatic test_balanced;
        bus.req = 4'b0001;
        repeat (8) tick();
        bus.req = 4'b0000;
        checks++;
        if (bus.count !== 5'd8) begin
            errors++;
            $display("FAIL bal_start: got %0d want 8", bus.count);
        end
        set_word(1, 32'hAAAA_AAAA);
        bus.req = 4'b0010;
        bus.pop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (bus.grant !== 4'b0010) begin
                errors++;
                $display("FAIL bal_grant[%0d]: got %b want 0010",
                         k, bus.grant);
            end
            tick();
            checks++;
            if (bus.count !== 5'd8) begin
                errors++;
                $display("FAIL bal_count[%0d]: got %0d want 8",
                         k, bus.count);
            end
        end
        bus.req = 4'b0000;
        bus.pop = 1'b0;
        #1;
        checks++;
        if (bus.rd_data !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL bal_head: got %h want aaaaaaaa", bus.rd_data);
        end
        rr_words();
        bus.pop = 1'b1;
        repeat (8) tick();
        bus.pop = 1'b0;
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL bal_empty: got %b want 1", bus.empty);
        end
    endtask

    task automatic test_boundaries;
        bus.req = 4'b0001;
        repeat (15) tick();
        checks++;
        if (bus.count !== 5'd15 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL bnd_15: got c=%0d f=%b want c=15 f=0",
                     bus.count, bus.full);
        end
        tick();
        checks++;
        if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL bnd_full: got c=%0d f=%b want c=16 f=1",
                     bus.count, bus.full);
        end
        bus.req = 4'b1111;
        bus.pop = 1'b1;
        #1;
        checks++;
        if (bus.grant !== 4'b0000) begin
            errors++;
            $display("FAIL bnd_full_pop_grant: got %b want 0000", bus.grant);
        end
        tick();
        bus.req = 4'b0000;
        checks++;
        if (bus.count !== 5'd15 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL bnd_full_pop: got c=%0d f=%b want c=15 f=0",
                     bus.count, bus.full);
        end
        repeat (14) tick();
        checks++;
        if (bus.count !== 5'd1 || bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL bnd_1: got c=%0d e=%b want c=1 e=0",
                     bus.count, bus.empty);
        end
        tick();
        bus.pop = 1'b0;
        checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL bnd_empty: got c=%0d e=%b want c=0 e=1",
                     bus.count, bus.empty);
        end
    endtask

    task automatic test_underflow;
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        checks++;
        if (bus.error_flag !== 1'b1 || bus.count !== 5'd0 ||
            bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL uf_set: got err=%b c=%0d e=%b want 1 0 1",
                     bus.error_flag, bus.count, bus.empty);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.error_flag !== 1'b1) begin
                errors++;
                $display("FAIL uf_hold[%0d]: got %b want 1",
                         k, bus.error_flag);
            end
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++;
        if (bus.error_flag !== 1'b0) begin
            errors++;
            $display("FAIL uf_clr: got %b want 0", bus.error_flag);
        end
        bus.pop = 1'b1;
        bus.err_clr = 1'b1;
        tick();
        bus.pop = 1'b0;
        bus.err_clr = 1'b0;
        checks++;
        if (bus.error_flag !== 1'b1) begin
            errors++;
            $display("FAIL uf_set_wins: got %b want 1", bus.error_flag);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++;
        if (bus.error_flag !== 1'b0) begin
            errors++;
            $display("FAIL uf_clr2: got %b want 0", bus.error_flag);
        end
        bus.pop = 1'b1;
        bus.req = 4'b0001;
        tick();
        bus.pop = 1'b0;
        bus.req = 4'b0000;
        checks++;
        if (bus.count !== 5'd1 || bus.error_flag !== 1'b1) begin
            errors++;
            $display("FAIL uf_push: got c=%0d err=%b want c=1 err=1",
                     bus.count, bus.error_flag);
        end
        bus.pop = 1'b1;
        bus.err_clr = 1'b1;
        tick();
        bus.pop = 1'b0;
        bus.err_clr = 1'b0;
        checks++;
        if (bus.count !== 5'd0 || bus.error_flag !== 1'b0) begin
            errors++;
            $display("FAIL uf_valid_pop: got c=%0d err=%b want c=0 err=0",
                     bus.count, bus.error_flag);
        end
    endtask

    task automatic test_withdrawn;
        logic [31:0] vals [3];
        vals[0] = 32'h0000_0000;
        vals[1] = 32'hFFFF_FFFF;
        vals[2] = 32'h5555_5555;
        bus.req = 4'b0001;
        repeat (16) tick();
        checks++;
        if (bus.full !== 1'b1) begin
            errors++;
            $display("FAIL wd_full: got %b want 1", bus.full);
        end
        #1;
        checks++;
        if (bus.grant[0] !== 1'b0) begin
            errors++;
            $display("FAIL wd_grant_held: got %b want 0", bus.grant[0]);
        end
        tick();
        bus.req = 4'b0000;
        #1;
        checks++;
        if (bus.grant !== 4'b0000 || bus.count !== 5'd16) begin
            errors++;
            $display("FAIL wd_dropped: got g=%b c=%0d want g=0000 c=16",
                     bus.grant, bus.count);
        end
        bus.pop = 1'b1;
        repeat (16) tick();
        bus.pop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_word(0, vals[k]);
            bus.req = 4'b0001;
            tick();
        end
        bus.req = 4'b0000;
        checks++;
        if (bus.count !== 5'd3) begin
            errors++;
            $display("FAIL wd_count3: got %0d want 3", bus.count);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.rd_data !== vals[k]) begin
                errors++;
                $display("FAIL wd_data[%0d]: got %h want %h",
                         k, bus.rd_data, vals[k]);
            end
            bus.pop = 1'b1;
            tick();
            bus.pop = 1'b0;
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL wd_empty: got %b want 1", bus.empty);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_rr_fill();
        test_balanced();
        test_boundaries();
        test_underflow();
        test_withdrawn();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_arb_fifo.md
# rr_arb_fifo

Four-requester round-robin arbiter feeding a 16-entry show-ahead FIFO. It produces the push/pop/full/empty/count/grant/error activity that the corner-case cover module observes. It sits between the requesting agents and a single downstream consumer that pops words in order.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `DATA_W`, 32: word width.
- `N_REQ`, 4: number of requesters; fixed at 4 for this revision.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  N_REQ: per-requester request; held until granted.
- `req_data`  in  N_REQ*DATA_W: requester i's word is at bits [i*DATA_W +: DATA_W].
- `grant`  out  N_REQ: one-hot or zero, combinational; the granted word is written at this edge.
- `pop`  in  1: consumer takes `rd_data` at this edge.
- `rd_data`  out  DATA_W: head word, valid when `!empty`.
- `full`  out  1: count == DEPTH.
- `empty`  out  1: count == 0.
- `count`  out  $clog2(DEPTH)+1: occupancy, 0..DEPTH.
- `err_clr`  in  1: clears `error_flag`.
- `error_flag`  out  1: sticky underflow indicator.

## Operation
- **Priority pointer** `prio` (2 bits): requester `prio` has highest priority, then prio+1, prio+2, prio+3, all mod 4.
- **Grant**
  - `grant` is the first requester with req high in pointer order, gated by `!full`.
  - If full, `grant` = 0 regardless of `pop`. There is no grant-on-pop-at-full path.
  - `grant` must never have more than one bit set.
- **Push** = |grant.
  - The granted requester's word is written to mem[wr_ptr] and wr_ptr increments (wraps at DEPTH).
  - `prio` moves to granted index + 1 (mod 4).
  - With no grant, `prio` holds.
- **Pop**
  - If `pop && !empty`: rd_ptr increments (wraps).
  - If `pop && empty`: underflow. Pointers and count are unchanged, and `error_flag` sets at the edge.
- **Count update**
  - push only: +1.
  - valid pop only: −1.
  - push and valid pop together: unchanged.
  - Underflow pop with simultaneous push: push proceeds, count +1, `error_flag` still sets.
- **rd_data** = mem[rd_ptr], combinational from storage (show-ahead). Content is don't-care when empty. Writing into an empty FIFO makes the word visible on `rd_data` the cycle after the push edge.
- **Error flag**
  - Sets on underflow and stays set.
  - `err_clr` clears it at the next edge.
  - If underflow and `err_clr` occur in the same cycle, set wins.
- **Overflow** cannot occur, because grant is gated by full. Implement an immediate assertion: push implies !full.
- **States** implied by count:
  - EMPTY (0)
  - PARTIAL (1..DEPTH−1)
  - FULL (DEPTH)
  - Transitions move by at most one step per cycle.

## Timing
- **Reset values** (all outputs and state):
  - count=0, empty=1, full=0, error_flag=0.
  - wr_ptr=rd_ptr=0, prio=0.
  - Because grant is combinational, grant = lowest-indexed asserted req while in reset.
  - mem contents are not reset.
- **Reset mid-operation**: all stored entries are discarded immediately, and flags take their reset values asynchronously.
- **Latency**: req → grant is 0 cycles (same cycle). Push → visible on `rd_data`/`empty` deasserted is 1 cycle.
- **Flag timing**: `full`, `empty` and `count` are registered (or decoded from registered count). They change only at rising edges after reset.
- **Fairness**: if all four requesters hold req continuously and the FIFO is not full, each is granted exactly once in any 4 consecutive grant cycles.
- **Pointer width**: pointers are $clog2(DEPTH) bits and wrap naturally. `count` carries the extra bit to distinguish full from empty.

## Test plan
1. **Reset**: assert rst_n=0 mid-stream at count=5 → count=0, empty=1, full=0, error_flag=0 immediately. After release with req=4'b0100, the first grant is 4'b0100.
2. **Round-robin fill**: req=4'b1111 with data i→32'h1000_000i, pop=0 → grants 0001, 0010, 0100, 1000, 0001…. After 16 grant cycles, full=1, count=16 and grant=0. A subsequent pop-only drain yields rd_data 1000_0000, …_0001, …_0002, …_0003, …_0000, … in that order.
3. **Balanced traffic**: at count=8, req=4'b0010 with data 32'hAAAA_AAAA and pop=1 for 10 cycles → count stays 8, and grant=0010 every cycle.
4. **Boundaries**: count=15 with a push → full next cycle. count=1 with pop → empty next cycle. At full, req=1111 and pop=1 → grant=0 and count=15 next cycle.
5. **Underflow and recovery**: pop=1 while empty → error_flag=1 next cycle, count stays 0. Hold 3 cycles, then err_clr=1 → error_flag=0. Underflow coinciding with err_clr=1 → error_flag=1.
6. **Request withdrawn**: req[0] for 1 cycle while req[1] has priority and FIFO full, then req[0] dropped → grant[0] never asserts. Values 0, FFFF_FFFF and 5555_5555 pushed → popped back unchanged.
